// File: rtl/cnn_pkg.sv
// cnn_pkg: sequencer state encoding, accelerator register map and source-word address helper.
package cnn_pkg;
  typedef enum logic [2:0] {IDLE, LD_RD, LD_WR, START, POLL, RES, STORE} state_t;
  localparam logic [6:0] ACC_A_BASE = 7'd0;
  localparam logic [6:0] ACC_B_BASE = 7'd16;
  localparam logic [6:0] ACC_START = 7'd32;
  localparam logic [6:0] ACC_RESULT = 7'd33;
  localparam logic [6:0] ACC_VALID = 7'd34;
  // Words 0..15 come from vector A, 16..31 from vector B.
  function automatic logic [31:0] word_addr(input logic [31:0] src_a, input logic [31:0] src_b, input logic [4:0] k);
    return (k[4] ? src_b : src_a) + {26'd0, k[3:0], 2'b00};
  endfunction
endpackage

// File: rtl/cnn_bus_req.sv
// cnn_bus_req: registered master request held until ready; a new issue may overlap the completing cycle.
module cnn_bus_req #(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          issue,
  input  logic          write,
  input  logic [AW-1:0] addr_n,
  input  logic [31:0]   wdata_n,
  input  logic          ready,
  output logic          rd_en,
  output logic          wr_en,
  output logic [AW-1:0] addr,
  output logic [31:0]   wdata,
  output logic          cmp
);
  assign cmp = (rd_en | wr_en) & ready;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
      addr <= '0;
      wdata <= '0;
    end else if (issue) begin
      rd_en <= !write;
      wr_en <= write;
      addr <= addr_n;
      wdata <= wdata_n;
    end else if (cmp) begin
      rd_en <= 1'b0;
      wr_en <= 1'b0;
    end
  end
endmodule

// File: rtl/cnn_job_seq.sv
// cnn_job_seq: loads two 16-word vectors into the CNN accelerator, starts it, polls for the
// result and stores it to memory; each next request is issued on the completing cycle.
module cnn_job_seq
  import cnn_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int ACC_START_BIT = 29
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        job_valid,
  output logic        job_ready,
  input  logic [31:0] job_src_a,
  input  logic [31:0] job_src_b,
  input  logic [31:0] job_dst,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [6:0]  acc_addr,
  output logic [31:0] acc_wdata,
  output logic        acc_wr_en,
  output logic        acc_rd_en,
  input  logic [31:0] acc_rdata,
  input  logic        acc_ready,
  output logic        busy,
  output logic        done,
  output logic        err
);
  localparam int PW = $clog2(TIMEOUT + 1);
  state_t state;
  logic [31:0] src_a, src_b, dst;
  logic [4:0] k;
  logic [PW-1:0] polls;
  logic last_poll, mem_issue, mem_write, mem_cmp, acc_issue, acc_write, acc_cmp;
  logic [31:0] mem_addr_n, mem_wdata_n, acc_wdata_n;
  logic [6:0] acc_addr_n;
  assign job_ready = state == IDLE;
  assign busy = state != IDLE;
  assign last_poll = polls == PW'(TIMEOUT - 1);
  always_comb begin
    mem_issue = 1'b0;
    mem_write = 1'b0;
    mem_addr_n = word_addr(src_a, src_b, k + 5'd1);
    mem_wdata_n = '0;
    acc_issue = 1'b0;
    acc_write = 1'b0;
    acc_addr_n = ACC_VALID;
    acc_wdata_n = '0;
    case (state)
      IDLE: begin
        mem_issue = job_valid;
        mem_addr_n = job_src_a;
      end
      LD_RD: begin
        acc_issue = mem_cmp;
        acc_write = 1'b1;
        acc_addr_n = (k[4] ? ACC_B_BASE : ACC_A_BASE) + {3'd0, k[3:0]};
        acc_wdata_n = mem_rdata;
      end
      LD_WR: begin
        mem_issue = acc_cmp && k != 5'd31;
        acc_issue = acc_cmp && k == 5'd31;
        acc_write = 1'b1;
        acc_addr_n = ACC_START;
        acc_wdata_n = 32'd1 << ACC_START_BIT;
      end
      START: acc_issue = acc_cmp;
      POLL: begin
        acc_issue = acc_cmp && (acc_rdata[0] || !last_poll);
        acc_addr_n = acc_rdata[0] ? ACC_RESULT : ACC_VALID;
      end
      RES: begin
        mem_issue = acc_cmp;
        mem_write = 1'b1;
        mem_addr_n = dst;
        mem_wdata_n = acc_rdata;
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      src_a <= '0;
      src_b <= '0;
      dst <= '0;
      k <= '0;
      polls <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= state == STORE && mem_cmp;
      err <= state == POLL && acc_cmp && !acc_rdata[0] && last_poll;
      case (state)
        IDLE: if (job_valid) begin
          state <= LD_RD;
          src_a <= job_src_a;
          src_b <= job_src_b;
          dst <= job_dst;
          k <= '0;
          polls <= '0;
        end
        LD_RD: if (mem_cmp) state <= LD_WR;
        LD_WR: if (acc_cmp) begin
          state <= k == 5'd31 ? START : LD_RD;
          k <= k + 5'd1;
        end
        START: if (acc_cmp) state <= POLL;
        POLL: if (acc_cmp) begin
          state <= acc_rdata[0] ? RES : last_poll ? IDLE : POLL;
          polls <= polls + PW'(1);
        end
        RES: if (acc_cmp) state <= STORE;
        STORE: if (mem_cmp) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  cnn_bus_req #(.AW(32)) mem_req (
    .clk(clk), .rst_n(rst_n), .issue(mem_issue), .write(mem_write), .addr_n(mem_addr_n),
    .wdata_n(mem_wdata_n), .ready(mem_ready), .rd_en(mem_rd_en), .wr_en(mem_wr_en),
    .addr(mem_addr), .wdata(mem_wdata), .cmp(mem_cmp)
  );
  cnn_bus_req #(.AW(7)) acc_req (
    .clk(clk), .rst_n(rst_n), .issue(acc_issue), .write(acc_write), .addr_n(acc_addr_n),
    .wdata_n(acc_wdata_n), .ready(acc_ready), .rd_en(acc_rd_en), .wr_en(acc_wr_en),
    .addr(acc_addr), .wdata(acc_wdata), .cmp(acc_cmp)
  );
endmodule

// File: tb/tb_cnn_job_seq.sv
// tb_cnn_job_seq: randomized jobs against a memory image and an accelerator model that
// computes the dot product of whatever was loaded into its registers.
module tb_cnn_job_seq;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic job_valid, job_ready, busy, done, err;
  logic [31:0] job_src_a, job_src_b, job_dst;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic mem_rd_en, mem_wr_en, mem_ready;
  logic [6:0] acc_addr;
  logic [31:0] acc_wdata, acc_rdata;
  logic acc_wr_en, acc_rd_en, acc_ready;

  cnn_job_seq #(.TIMEOUT(TO), .ACC_START_BIT(29)) dut (
    .clk(clk), .rst_n(rst_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_src_a(job_src_a), .job_src_b(job_src_b), .job_dst(job_dst),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_wr_en(acc_wr_en), .acc_rd_en(acc_rd_en),
    .acc_rdata(acc_rdata), .acc_ready(acc_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, cyc = 0;
  int mem_lat = 0, valid_after = 3, polls = 0;
  int poll_reads = 0, result_reads = 0, start_writes = 0, mem_reads = 0, bad_acc = 0;
  int done_cnt = 0, err_cnt = 0, done_cyc = 0, accepts = 0, accept_cyc = 0;
  int excl_viol = 0, hold_viol = 0, drop_viol = 0, mem_cnt = 0;
  logic [31:0] start_data = '0;
  logic [31:0] mem_img [bit [31:0]];
  logic [31:0] acc_regs [32];
  logic [31:0] exp_regs [32];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  logic [31:0] h_addr, h_wdata;
  logic h_rd, h_wr;
  bit waiting = 0;

  function automatic logic [31:0] acc_dot();
    logic [31:0] s = '0;
    for (int i = 0; i < 16; i++) s = s + acc_regs[i] * acc_regs[16 + i];
    return s;
  endfunction

  function automatic logic [31:0] rnd_addr(input logic [3:0] hi);
    return {hi, 4'h0, 12'($urandom), 12'h000};
  endfunction

  // Acceptance is counted on the edge itself, where the DUT samples it.
  initial forever begin
    @(posedge clk);
    if (rst_n && job_valid && job_ready) begin
      accepts++;
      accept_cyc = cyc;
    end
    cyc++;
  end

  // Memory and accelerator responders, driving their inputs just after the falling edge.
  initial begin
    mem_ready = 1'b0;
    acc_ready = 1'b0;
    mem_rdata = '0;
    acc_rdata = '0;
    forever begin
      logic [31:0] tmp;
      @(negedge clk);
      #1;
      if (((mem_rd_en || mem_wr_en) && (acc_rd_en || acc_wr_en)) || (mem_rd_en && mem_wr_en) || (acc_rd_en && acc_wr_en))
        excl_viol++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (err) err_cnt++;
      if (mem_rd_en || mem_wr_en) begin
        if (waiting && (mem_addr !== h_addr || mem_wdata !== h_wdata || mem_rd_en !== h_rd || mem_wr_en !== h_wr))
          hold_viol++;
        if (mem_cnt >= mem_lat) begin
          mem_ready = 1'b1;
          waiting = 0;
          mem_cnt = 0;
          if (mem_rd_en) begin
            mem_reads++;
            mem_rdata = mem_img.exists(mem_addr) ? mem_img[mem_addr] : 32'hDEAD_BEEF;
          end else begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
          end
        end else begin
          if (!waiting) {h_addr, h_wdata, h_rd, h_wr} = {mem_addr, mem_wdata, mem_rd_en, mem_wr_en};
          waiting = 1;
          mem_cnt++;
          mem_ready = 1'b0;
          mem_rdata = $urandom;
        end
      end else begin
        if (waiting) drop_viol++;
        waiting = 0;
        mem_cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
      end
      tmp = $urandom;
      acc_rdata = tmp;
      acc_ready = acc_wr_en || acc_rd_en;
      if (acc_wr_en) begin
        if (acc_addr < 7'd32) acc_regs[acc_addr[4:0]] = acc_wdata;
        else if (acc_addr == 7'd32) begin
          start_writes++;
          start_data = acc_wdata;
          polls = 0;
        end else bad_acc++;
      end else if (acc_rd_en) begin
        if (acc_addr == 7'd34) begin
          poll_reads++;
          polls++;
          tmp[0] = valid_after != 0 && polls >= valid_after;
          acc_rdata = tmp;
        end else if (acc_addr == 7'd33) begin
          result_reads++;
          acc_rdata = acc_dot();
        end else bad_acc++;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_stats();
    wr_addr_q.delete();
    wr_data_q.delete();
    mem_img.delete();
    poll_reads = 0; result_reads = 0; start_writes = 0; mem_reads = 0;
    bad_acc = 0; hold_viol = 0; drop_viol = 0; start_data = '0;
    for (int i = 0; i < 32; i++) acc_regs[i] = '0;
  endtask

  // Reference: vectors in the memory image, expected register contents and dot product.
  task automatic setup_job(input logic [31:0] sa, input logic [31:0] sb, input bit fixed, output logic [31:0] res);
    logic [31:0] a, b;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      a = fixed ? 32'(i + 1) : $urandom;
      b = fixed ? 32'd2 : $urandom;
      mem_img[sa + 32'(4 * i)] = a;
      mem_img[sb + 32'(4 * i)] = b;
      exp_regs[i] = a;
      exp_regs[16 + i] = b;
      res = res + a * b;
    end
  endtask

  task automatic start_job(input logic [31:0] sa, input logic [31:0] sb, input logic [31:0] dst, output bit ok);
    int a0 = accepts;
    ok = 0;
    @(negedge clk);
    job_src_a = sa; job_src_b = sb; job_dst = dst; job_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (accepts != a0) begin
        ok = 1;
        break;
      end
    end
    job_valid = 1'b0;
    job_src_a = $urandom; job_src_b = $urandom; job_dst = $urandom;
  endtask

  task automatic wait_end(output bit ok);
    int d0 = done_cnt, e0 = err_cnt;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt != d0 || err_cnt != e0) begin
        ok = 1;
        break;
      end
    end
  endtask

  function automatic int regs_bad();
    int bad = 0;
    for (int i = 0; i < 32; i++) bad += int'(acc_regs[i] !== exp_regs[i]);
    return bad;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (job_ready !== 1'b1) $display("FAIL reset_job_ready: got %b want 1", job_ready); else n_pass++;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
    n_chk++; if ({mem_rd_en, mem_wr_en, acc_rd_en, acc_wr_en} !== 4'b0) $display("FAIL reset_enables: got %b want 0000", {mem_rd_en, mem_wr_en, acc_rd_en, acc_wr_en}); else n_pass++;
    n_chk++; if ({done, err} !== 2'b0) $display("FAIL reset_pulses: got %b want 00", {done, err}); else n_pass++;
    n_chk++; if ({mem_addr, mem_wdata, acc_addr, acc_wdata} !== '0) $display("FAIL reset_buses: got %h want 0", {mem_addr, mem_wdata, acc_addr, acc_wdata}); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] sa, sb, dst, res, got;
    bit ok;
    int d0, e0;
    clear_stats();
    mem_lat = 0; valid_after = 3;
    sa = rnd_addr(4'h1); sb = rnd_addr(4'h2); dst = rnd_addr(4'h3);
    setup_job(sa, sb, 1'b1, res);
    d0 = done_cnt; e0 = err_cnt;
    start_job(sa, sb, dst, ok);
    if (ok) wait_end(ok);
    n_chk++; if (ok !== 1'b1) $display("FAIL basic_end: got no done within bound, want done"); else n_pass++;
    n_chk++; if (regs_bad() !== 0) $display("FAIL basic_regs: %0d of 32 registers wrong, want 0", regs_bad()); else n_pass++;
    n_chk++; if (start_data !== 32'h2000_0000 || start_writes !== 1) $display("FAIL basic_start: got %h x%0d want 20000000 x1", start_data, start_writes); else n_pass++;
    n_chk++; if (poll_reads !== 3 || result_reads !== 1 || mem_reads !== 32 || bad_acc !== 0) $display("FAIL basic_reads: got polls %0d res %0d mem %0d bad %0d want 3 1 32 0", poll_reads, result_reads, mem_reads, bad_acc); else n_pass++;
    got = wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx;
    n_chk++; if (wr_addr_q.size() !== 1 || got !== dst) $display("FAIL basic_store_addr: got %h (%0d writes) want %h (1 write)", got, wr_addr_q.size(), dst); else n_pass++;
    got = wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx;
    n_chk++; if (got !== 32'd272 || got !== res) $display("FAIL basic_store_data: got %0d want %0d", got, res); else n_pass++;
    n_chk++; if (done_cnt - d0 !== 1 || err_cnt !== e0) $display("FAIL basic_pulses: got done %0d err %0d want 1 0", done_cnt - d0, err_cnt - e0); else n_pass++;
    n_chk++; if (done_cyc - accept_cyc !== 71) $display("FAIL basic_latency: got %0d want 71", done_cyc - accept_cyc); else n_pass++;
    n_chk++; if (job_ready !== 1'b1 || busy !== 1'b0) $display("FAIL basic_idle: got ready %b busy %b want 1 0", job_ready, busy); else n_pass++;
    @(negedge clk);
    n_chk++; if (done !== 1'b0) $display("FAIL basic_done_width: got %b want 0", done); else n_pass++;
  endtask

  task automatic test_wait_states();
    logic [31:0] sa, sb, dst, res, got;
    bit ok;
    int p;
    clear_stats();
    mem_lat = 3;
    p = $urandom_range(1, TO - 1);
    valid_after = p;
    sa = rnd_addr(4'h4); sb = rnd_addr(4'h5); dst = rnd_addr(4'h6);
    setup_job(sa, sb, 1'b0, res);
    start_job(sa, sb, dst, ok);
    if (ok) wait_end(ok);
    mem_lat = 0;
    n_chk++; if (ok !== 1'b1 || err_cnt !== 0) $display("FAIL wait_end: got ok %b err %0d want 1 0", ok, err_cnt); else n_pass++;
    n_chk++; if (hold_viol !== 0 || drop_viol !== 0) $display("FAIL wait_hold: got hold %0d drop %0d want 0 0", hold_viol, drop_viol); else n_pass++;
    n_chk++; if (regs_bad() !== 0) $display("FAIL wait_regs: %0d of 32 registers wrong, want 0", regs_bad()); else n_pass++;
    got = wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx;
    n_chk++; if (wr_data_q.size() !== 1 || got !== res || wr_addr_q[0] !== dst) $display("FAIL wait_store: got %h (%0d writes) want %h at %h", got, wr_data_q.size(), res, dst); else n_pass++;
    n_chk++; if (done_cyc - accept_cyc !== 68 + p + 33 * 3) $display("FAIL wait_latency: got %0d want %0d", done_cyc - accept_cyc, 68 + p + 99); else n_pass++;
  endtask

  task automatic test_timeout();
    logic [31:0] sa, sb, dst, res;
    bit ok;
    int d0, e0;
    clear_stats();
    valid_after = 0;
    sa = rnd_addr(4'h7); sb = rnd_addr(4'h8); dst = rnd_addr(4'h9);
    setup_job(sa, sb, 1'b0, res);
    d0 = done_cnt; e0 = err_cnt;
    start_job(sa, sb, dst, ok);
    if (ok) wait_end(ok);
    n_chk++; if (ok !== 1'b1 || err_cnt - e0 !== 1 || done_cnt !== d0) $display("FAIL timeout_pulses: got ok %b err %0d done %0d want 1 1 0", ok, err_cnt - e0, done_cnt - d0); else n_pass++;
    n_chk++; if (poll_reads !== TO || result_reads !== 0) $display("FAIL timeout_polls: got %0d polls %0d result reads want %0d 0", poll_reads, result_reads, TO); else n_pass++;
    n_chk++; if (wr_addr_q.size() !== 0) $display("FAIL timeout_no_store: got %0d writes want 0", wr_addr_q.size()); else n_pass++;
    n_chk++; if (job_ready !== 1'b1 || busy !== 1'b0) $display("FAIL timeout_idle: got ready %b busy %b want 1 0", job_ready, busy); else n_pass++;
    @(negedge clk);
    n_chk++; if (err !== 1'b0 || {acc_rd_en, mem_wr_en} !== 2'b0) $display("FAIL timeout_after: got err %b en %b want 0 00", err, {acc_rd_en, mem_wr_en}); else n_pass++;
  endtask

  task automatic test_reset_mid_job();
    logic [31:0] sa, sb, dst, res, got;
    bit ok, hit;
    clear_stats();
    valid_after = $urandom_range(1, 4);
    sa = rnd_addr(4'hA); sb = rnd_addr(4'hB); dst = rnd_addr(4'hC);
    setup_job(sa, sb, 1'b0, res);
    start_job(sa, sb, dst, ok);
    hit = 0;
    for (int i = 0; i < 200 && ok; i++) begin
      @(negedge clk);
      if (acc_wr_en && acc_addr == 7'd17) begin
        hit = 1;
        break;
      end
    end
    n_chk++; if (hit !== 1'b1) $display("FAIL rstmid_reach_k17: got no write to 17 want one"); else n_pass++;
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    n_chk++; if (job_ready !== 1'b1 || busy !== 1'b0) $display("FAIL rstmid_idle: got ready %b busy %b want 1 0", job_ready, busy); else n_pass++;
    n_chk++; if ({mem_rd_en, mem_wr_en, acc_rd_en, acc_wr_en} !== 4'b0) $display("FAIL rstmid_enables: got %b want 0000", {mem_rd_en, mem_wr_en, acc_rd_en, acc_wr_en}); else n_pass++;
    rst_n = 1'b1;
    clear_stats();
    sa = rnd_addr(4'hD) | 32'h2; sb = rnd_addr(4'hE) | 32'h1; dst = rnd_addr(4'hF) | 32'h3;
    setup_job(sa, sb, 1'b0, res);
    start_job(sa, sb, dst, ok);
    n_chk++; if (mem_rd_en !== 1'b1 || mem_addr !== sa) $display("FAIL rstmid_restart: got en %b addr %h want 1 %h", mem_rd_en, mem_addr, sa); else n_pass++;
    if (ok) wait_end(ok);
    n_chk++; if (ok !== 1'b1 || regs_bad() !== 0) $display("FAIL rstmid_regs: got ok %b with %0d bad registers want 1 0", ok, regs_bad()); else n_pass++;
    got = wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx;
    n_chk++; if (wr_data_q.size() !== 1 || got !== res || wr_addr_q[0] !== dst) $display("FAIL rstmid_store: got %h (%0d writes) want %h at %h", got, wr_data_q.size(), res, dst); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] sa1, sb1, d1, sa2, sb2, d2, r1, r2;
    int a0, d0, d1c, ac2, phase, pulses;
    clear_stats();
    valid_after = $urandom_range(1, 4);
    sa1 = rnd_addr(4'h1); sb1 = rnd_addr(4'h2); d1 = rnd_addr(4'h3);
    sa2 = rnd_addr(4'h5); sb2 = rnd_addr(4'h6); d2 = rnd_addr(4'h7);
    setup_job(sa1, sb1, 1'b0, r1);
    setup_job(sa2, sb2, 1'b0, r2);
    a0 = accepts; d0 = done_cnt; d1c = -1; ac2 = -2; phase = 0; pulses = 0;
    @(negedge clk);
    job_src_a = sa1; job_src_b = sb1; job_dst = d1; job_valid = 1'b1;
    for (int i = 0; i < 1000 && done_cnt < d0 + 2; i++) begin
      @(negedge clk);
      #2;
      if (done_cnt == d0 + 1 && d1c < 0) d1c = done_cyc;
      if (phase == 0 && accepts == a0 + 1) begin
        job_src_a = sa2; job_src_b = sb2; job_dst = d2;
        phase = 1;
      end else if (phase == 1 && accepts == a0 + 2) begin
        ac2 = accept_cyc;
        phase = 2;
      end else if (phase == 2) begin
        pulses++;
        job_valid = pulses < 20 ? 1'($urandom) : 1'b0;
        job_src_a = $urandom; job_src_b = $urandom; job_dst = $urandom;
      end
    end
    job_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++; if (done_cnt - d0 !== 2) $display("FAIL b2b_done_count: got %0d want 2", done_cnt - d0); else n_pass++;
    n_chk++; if (accepts - a0 !== 2) $display("FAIL b2b_accepts: got %0d want 2", accepts - a0); else n_pass++;
    n_chk++; if (ac2 !== d1c) $display("FAIL b2b_accept_on_done: got cycle %0d want %0d", ac2, d1c); else n_pass++;
    n_chk++; if (wr_addr_q.size() !== 2 || wr_addr_q[0] !== d1 || wr_data_q[0] !== r1) $display("FAIL b2b_store1: got %0d writes first %h=%h want %h=%h", wr_addr_q.size(), wr_addr_q.size() > 0 ? wr_addr_q[0] : 32'hx, wr_data_q.size() > 0 ? wr_data_q[0] : 32'hx, d1, r1); else n_pass++;
    n_chk++; if (wr_addr_q.size() !== 2 || wr_addr_q[1] !== d2 || wr_data_q[1] !== r2) $display("FAIL b2b_store2: got %0d writes want second %h=%h", wr_addr_q.size(), d2, r2); else n_pass++;
    n_chk++; if (regs_bad() !== 0) $display("FAIL b2b_regs: %0d of 32 registers wrong, want 0", regs_bad()); else n_pass++;
    n_chk++; if (excl_viol !== 0) $display("FAIL exclusive_enables: got %0d overlapping cycles want 0", excl_viol); else n_pass++;
  endtask

  initial begin
    job_valid = 1'b0;
    job_src_a = '0; job_src_b = '0; job_dst = '0;
    test_reset();
    test_basic();
    test_wait_states();
    test_timeout();
    test_reset_mid_job();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
